// File: rtl/iob_fifo2p_ctrl_pkg.sv
// Shared sizing helpers for the two-port FIFO controller and its pointer counters.
package iob_fifo2p_ctrl_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  // Level counts 0..depth inclusive, so it needs one bit more than the address.
  function automatic int fifo_level_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/iob_fifo2p_ptr.sv
// Wrapping FIFO pointer: W-bit counter with enable and asynchronous active-high reset.
module iob_fifo2p_ptr
  import iob_fifo2p_ctrl_pkg::*;
#(
  parameter int W = fifo_level_w(DEF_ADDR_W)
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         en_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= ptr_q + W'(1);
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/iob_fifo2p_ctrl.sv
// Two-port FIFO controller driving an external RAM with 1-cycle registered read.
// Optional sticky overflow/underflow flags are enabled by macro IOB_FIFO2P_CTRL_ERR_EN.
module iob_fifo2p_ctrl
  import iob_fifo2p_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                            clk_i,
  input  logic                            arst_i,
  input  logic                            w_en_i,
  input  logic [DATA_W-1:0]               w_data_i,
  output logic                            w_full_o,
  input  logic                            r_en_i,
  output logic [DATA_W-1:0]               r_data_o,
  output logic                            r_valid_o,
  output logic                            r_empty_o,
  output logic [fifo_level_w(ADDR_W)-1:0] level_o,
  output logic                            ext_mem_w_en_o,
  output logic [ADDR_W-1:0]               ext_mem_w_addr_o,
  output logic [DATA_W-1:0]               ext_mem_w_data_o,
  output logic                            ext_mem_r_en_o,
  output logic [ADDR_W-1:0]               ext_mem_r_addr_o,
  input  logic [DATA_W-1:0]               ext_mem_r_data_i,
  output logic                            overflow_o,
  output logic                            underflow_o
);

  localparam int LEVEL_W = fifo_level_w(ADDR_W);
  localparam int DEPTH   = fifo_depth(ADDR_W);

  logic               push, pop;
  logic [ADDR_W:0]    w_ptr, r_ptr;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               full_q, empty_q, valid_q;

  // Gating by the registered flags gives pop priority when full and push priority when empty.
  assign push = w_en_i & ~full_q;
  assign pop  = r_en_i & ~empty_q;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LEVEL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LEVEL_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      level_q <= level_d;
      full_q  <= (level_d == LEVEL_W'(DEPTH));
      empty_q <= (level_d == '0);
      valid_q <= pop;
    end
  end

  iob_fifo2p_ptr #(.W(ADDR_W + 1)) u_w_ptr (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .en_i   (push),
    .ptr_o  (w_ptr)
  );

  iob_fifo2p_ptr #(.W(ADDR_W + 1)) u_r_ptr (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .en_i   (pop),
    .ptr_o  (r_ptr)
  );

  assign ext_mem_w_en_o   = push;
  assign ext_mem_w_addr_o = w_ptr[ADDR_W-1:0];
  assign ext_mem_w_data_o = w_data_i;
  assign ext_mem_r_en_o   = pop;
  assign ext_mem_r_addr_o = r_ptr[ADDR_W-1:0];

  assign w_full_o  = full_q;
  assign r_empty_o = empty_q;
  assign level_o   = level_q;
  assign r_valid_o = valid_q;
  assign r_data_o  = ext_mem_r_data_i;

`ifdef IOB_FIFO2P_CTRL_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (w_en_i & full_q);
      udf_q <= udf_q | (r_en_i & empty_q);
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule
